// File: rtl/rot_sq_multi.sv
// Rotating square on an N_DIG-digit multiplexed common-anode seven-segment display.
// Optional pause blink enabled by defining ROT_SQ_PAUSE_BLINK_EN.
module rot_sq_multi #(
    parameter int N_DIG    = 4,
    parameter int STEP_DIV = 50000000,
    parameter int SCAN_DIV = 50000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          cw,
    input  logic [1:0]                    speed,
    output logic [6:0]                    sseg,
    output logic [N_DIG-1:0]              an,
    output logic [$clog2(2*N_DIG)-1:0]    pos,
    output logic                          wrap
);

    localparam int PW = $clog2(2*N_DIG);
    localparam int DW = $clog2(N_DIG);
    localparam int SW = $clog2(STEP_DIV+1);
    localparam int CW = $clog2(SCAN_DIV+1);

    localparam logic [SW-1:0]    STEP_FULL = SW'(STEP_DIV);
    localparam logic [CW-1:0]    SCAN_LAST = CW'(SCAN_DIV-1);
    localparam logic [DW-1:0]    DIG_LAST  = DW'(N_DIG-1);
    localparam logic [PW-1:0]    NP        = PW'(N_DIG);
    localparam logic [PW-1:0]    NM1       = PW'(N_DIG-1);
    localparam logic [PW-1:0]    POS_MAX   = PW'(2*N_DIG-1);
    localparam logic [N_DIG-1:0] ONE       = N_DIG'(1);
    localparam logic [6:0]       SEG_UP    = 7'b0011100;
    localparam logic [6:0]       SEG_LO    = 7'b0100011;

    logic [SW-1:0]    step_cnt;
    logic [SW-1:0]    term;
    logic             tick;
    logic [CW-1:0]    scan_cnt;
    logic [DW-1:0]    dig;
    logic             blink;
    logic             upper;
    logic [PW-1:0]    lit;
    logic [6:0]       pat;
    logic [N_DIG-1:0] an_nxt;

    // ">=" rather than "==" so a speed increase mid-count ticks immediately
    always_comb begin
        term = (STEP_FULL >> speed) - SW'(1);
        tick = (step_cnt >= term);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step_cnt <= '0;
        end else if (tick) begin
            step_cnt <= '0;
        end else begin
            step_cnt <= step_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pos  <= '0;
            wrap <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (tick && en) begin
                if (cw) begin
                    if (pos == POS_MAX) begin
                        pos  <= '0;
                        wrap <= 1'b1;
                    end else begin
                        pos <= pos + PW'(1);
                    end
                end else begin
                    if (pos == '0) begin
                        pos  <= POS_MAX;
                        wrap <= 1'b1;
                    end else begin
                        pos <= pos - PW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_cnt <= '0;
            dig      <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            dig      <= (dig == DIG_LAST) ? '0 : dig + DW'(1);
        end else begin
            scan_cnt <= scan_cnt + CW'(1);
        end
    end

`ifdef ROT_SQ_PAUSE_BLINK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink <= 1'b0;
        end else if (en) begin
            blink <= 1'b0;
        end else if (tick) begin
            blink <= ~blink;
        end
    end
`else
    assign blink = 1'b0;
`endif

    // upper half runs left-to-right from digit N-1, lower half right-to-left from digit 0
    always_comb begin
        upper  = (pos < NP);
        lit    = upper ? (NM1 - pos) : (pos - NP);
        pat    = 7'h7F;
        if (!blink && (PW'(dig) == lit)) begin
            pat = upper ? SEG_UP : SEG_LO;
        end
        an_nxt = ~(ONE << dig);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an   <= '1;
            sseg <= 7'h7F;
        end else begin
            an   <= an_nxt;
            sseg <= pat;
        end
    end

endmodule

// File: tb/tb_rot_sq_multi.sv
// Self-checking bench for rot_sq_multi (N_DIG=4, STEP_DIV=16, SCAN_DIV=4) against a behavioural model.
module tb_rot_sq_multi;

    localparam int N  = 4;
    localparam int SD = 16;
    localparam int SC = 4;

    logic       clk;
    logic       reset;
    logic       en;
    logic       cw;
    logic [1:0] speed;
    logic [6:0] sseg;
    logic [3:0] an;
    logic [2:0] pos;
    logic       wrap;

    int checks = 0;
    int errors = 0;

    rot_sq_multi #(.N_DIG(N), .STEP_DIV(SD), .SCAN_DIV(SC)) dut (
        .clk(clk), .reset(reset), .en(en), .cw(cw), .speed(speed),
        .sseg(sseg), .an(an), .pos(pos), .wrap(wrap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] model_seg(input int d, input int p, input bit b);
        int litd;
        if (b) return 7'h7F;
        litd = (p < N) ? (N - 1 - p) : (p - N);
        if (d != litd) return 7'h7F;
        return (p < N) ? 7'b0011100 : 7'b0100011;
    endfunction

    // Behavioural reference: time-based tick, modular position, digit from edge count
    int         m_since, m_pos, m_edges, m_dig, m_nxt;
    bit         m_tick, m_wrap, m_blink;
    logic [3:0] m_an;
    logic [6:0] m_sseg;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_since = 0; m_pos = 0; m_edges = 0; m_wrap = 0; m_blink = 0;
            m_an = 4'hF; m_sseg = 7'h7F;
        end else begin
            m_tick = (m_since + 1 >= (SD >> speed));
            m_dig  = (m_edges / SC) % N;
            m_an   = ~(4'b0001 << m_dig);
            m_sseg = model_seg(m_dig, m_pos, m_blink);
            m_wrap = 0;
            if (m_tick && en) begin
                m_nxt  = cw ? (m_pos + 1) % (2*N) : (m_pos + 2*N - 1) % (2*N);
                m_wrap = cw ? (m_nxt == 0) : (m_nxt == 2*N - 1);
                m_pos  = m_nxt;
            end
`ifdef ROT_SQ_PAUSE_BLINK_EN
            if (en) m_blink = 0;
            else if (m_tick) m_blink = ~m_blink;
`endif
            m_since = m_tick ? 0 : m_since + 1;
            m_edges++;
        end
    end

    always @(negedge clk) begin
        check("pos", int'(pos), m_pos);
        check("wrap", int'(wrap), int'(m_wrap));
        check("an", int'(an), int'(m_an));
        check("sseg", int'(sseg), int'(m_sseg));
    end

    task automatic wait_until_pos(input int target, input int limit);
        int k = 0;
        while (int'(pos) != target && k < limit) begin
            @(negedge clk);
            k++;
        end
        check("wait_pos", int'(pos), target);
    endtask

    task automatic wait_change(input int limit, output int n);
        int p0 = int'(pos);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (int'(pos) == p0 && n < limit);
        check("wait_change", int'(int'(pos) != p0), 1);
    endtask

    initial begin
        int n;
        int pb;
        reset = 1'b1; en = 1'b0; cw = 1'b1; speed = 2'd0;

        #2 reset = 1'b0;
        #1;
        check("rst_an", int'(an), 4'hF);
        check("rst_sseg", int'(sseg), 7'h7F);
        check("rst_pos", int'(pos), 0);
        check("rst_wrap", int'(wrap), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        n = 0;
        while (an != 4'b0111 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("first_scan_an", int'(an), 4'b0111);
        check("first_scan_sseg", int'(sseg), 7'b0011100);

        en = 1'b1;
        wait_change(40, n);
        wait_change(40, n);
        check("step_period16", n, 16);
        wait_until_pos(7, 200);
        wait_change(40, n);
        check("cw_wrap_pos", int'(pos), 0);
        check("cw_wrap_pulse", int'(wrap), 1);
        @(negedge clk);
        check("cw_wrap_one_cycle", int'(wrap), 0);

        wait_until_pos(5, 200);
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            if (an == 4'b1101) check("pos5_lower_digit1", int'(sseg), 7'b0100011);
            if (an == 4'b1110) check("pos5_digit0_blank", int'(sseg), 7'h7F);
            @(negedge clk);
        end

        wait_until_pos(0, 200);
        cw = 1'b0;
        wait_change(40, n);
        check("ccw_wrap_pos", int'(pos), 7);
        check("ccw_wrap_pulse", int'(wrap), 1);
        @(negedge clk);
        check("ccw_wrap_one_cycle", int'(wrap), 0);
        wait_change(40, n);
        check("ccw_next", int'(pos), 6);

        en = 1'b0;
        pb = int'(pos);
        repeat (200) @(negedge clk);
        check("pause_hold", int'(pos), pb);
        en = 1'b1;
        wait_change(40, n);
        check("resume_ccw", int'(pos), (pb + 7) % 8);

        cw = 1'b1;
        speed = 2'd2;
        wait_change(40, n);
        wait_change(40, n);
        check("speed2_period", n, 4);

        speed = 2'd0;
        wait_change(40, n);
        repeat (10) @(negedge clk);
        pb = int'(pos);
        speed = 2'd3;
        @(negedge clk);
        check("speed_drop_tick", int'(pos), (pb + 1) % 8);
        wait_change(40, n);
        check("speed3_period", n, 2);

        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if ($urandom_range(15) == 0) begin
                en    = ($urandom_range(3) != 0);
                cw    = 1'($urandom_range(1));
                speed = 2'($urandom_range(3));
            end
        end

        en = 1'b1; cw = 1'b1; speed = 2'd2;
        wait_until_pos(6, 100);
        #2 reset = 1'b0;
        #1;
        check("midrst_an", int'(an), 4'hF);
        check("midrst_sseg", int'(sseg), 7'h7F);
        check("midrst_pos", int'(pos), 0);
        check("midrst_wrap", int'(wrap), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_pos", int'(pos), 0);
        check("post_rst_wrap", int'(wrap), 0);
        repeat (40) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
